buf_writer_gen: RTL and testbench
=================================

Name: buf_writer_gen

Overview:
Stimulus/loader block that streams a deterministic word sequence into a global buffer.
While load is high it emits one write per clock: a sequential buffer address, a data word, and a PE column tag.
The tag groups consecutive words into kernel_size-long runs per PE column.
Three instances (ifmap, filter, psum) feed the global buffer's write ports during the load phase.

Parameters:
DATA_WIDTH, 16, width of data_out (the psum instance uses 32)
NUM_COL, 10, number of PE columns; tag range 1..NUM_COL
BUFFER_SIZE, 512, buffer depth; words per full burst

Ports:
clk  in  1  bus clock, rising edge
rstn  in  1  asynchronous active-low reset
load  in  1  burst enable; high = emit one word per cycle
kernel_size  in  8  words per PE-column group; 0 treated as 1
data_out  out  DATA_WIDTH  write data
id_out  out  $clog2(NUM_COL)+1  PE column tag; 0 = no target, 1..NUM_COL = valid
addr_out  out  $clog2(BUFFER_SIZE)  buffer write address
valid_out  out  1  high while the current outputs are a valid write
done  out  1  high after BUFFER_SIZE words have been emitted in the burst

Behaviour:
- Reset (async, rstn=0): all outputs 0; state IDLE; word counter, group counter and column counter cleared; latched kernel size = 1.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE + load=1: latch ks = max(kernel_size,1) on that edge and emit word 0 on the same edge.
  - Registered outputs, so data appears one cycle after load is first sampled high.
  - Next state RUN.
- Word n output, n = 0..BUFFER_SIZE-1:
  - addr_out = n
  - data_out = (n+1) mod 2^DATA_WIDTH
  - id_out = ((n / ks) mod NUM_COL) + 1
  - valid_out = 1
- Counters: a group counter counts 0..ks-1.
  - On wrap it advances the column counter.
  - The column counter wraps from NUM_COL-1 to 0.
  - No divider is used.
- RUN + load=0: go to PAUSE.
  - valid_out=0, id_out=0; addr_out and data_out hold their last values.
  - Counters are retained.
- PAUSE + load=1: resume with word n+1 on that edge. ks is not re-latched.
- kernel_size changes during RUN/PAUSE are ignored until the next IDLE->RUN transition.
- After word BUFFER_SIZE-1 is emitted, the next edge enters DONE.
  - done=1, valid_out=0, id_out=0; the address does not wrap.
- DONE + load=0: return to IDLE, clear done and all counters. The next burst restarts at word 0.
- DONE + load=1: stay in DONE; no writes are emitted.
- Reset mid-burst clears everything immediately, regardless of clk.
- All outputs are registered; no combinational path from load to outputs.

Test Plan:
- Reset: hold rstn=0 with load=1 -> all outputs 0, valid_out=0, done=0. Release -> first word appears on the next rising edge.
- Basic burst (ks=5, NUM_COL=10, load high 50 cycles):
  - addr 0..49, data 1..50.
  - id 1 for words 0-4, 2 for 5-9, ..., 10 for 45-49.
  - After load drops: valid_out=0, id_out=0, addr holds 49.
- Pause/resume: load high for words 0-6, low 3 cycles, high again -> next word is addr 7, data 8, id 2. kernel_size change to 3 during the pause has no effect.
- Full burst (ks=5, load held high) -> last word addr 511, data 512, id 3. Next cycle done=1, valid_out=0, no further writes. load low -> done=0. load high -> restarts at addr 0, id 1.
- Kernel size 0 and wide data: kernel_size=0 -> id increments every word, wrapping 10->1 at word 10. DATA_WIDTH=32 instance -> data_out = n+1 zero-extended.
- Async reset mid-burst at word 20 -> outputs 0 without waiting for a clk edge. Next load starts at addr 0 with a fresh ks latch.

Source files
------------

// File: rtl/buf_writer_gen_if.sv
// Write-port bundle between a buffer loader and the global buffer.
//   load, kernel_size : burst control into the loader
//   data_out          : write data
//   id_out            : PE column tag (0 = no target, 1..NUM_COL = valid)
//   addr_out          : buffer write address
//   valid_out, done   : write strobe and burst-complete flag
interface buf_writer_gen_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_COL     = 10,
  parameter int BUFFER_SIZE = 512
);
  logic                           load;
  logic [7:0]                     kernel_size;
  logic [DATA_WIDTH-1:0]          data_out;
  logic [$clog2(NUM_COL):0]       id_out;
  logic [$clog2(BUFFER_SIZE)-1:0] addr_out;
  logic                           valid_out;
  logic                           done;

  modport master (
    input  load, kernel_size,
    output data_out, id_out, addr_out, valid_out, done
  );

  modport slave (
    output load, kernel_size,
    input  data_out, id_out, addr_out, valid_out, done
  );
endinterface

// File: rtl/buf_writer_gen.sv
// Global-buffer loader: while load is high, emits one write per clock with a
// sequential address, data = address+1, and a PE column tag that advances
// every kernel_size words and wraps over NUM_COL columns.
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : master side of buf_writer_gen_if (load/kernel_size in, write port out)
module buf_writer_gen #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_COL     = 10,
  parameter int BUFFER_SIZE = 512
) (
  input  logic                 clk,
  input  logic                 rstn,
  buf_writer_gen_if.master     bus
);
  localparam int AW = $clog2(BUFFER_SIZE);
  localparam int IW = $clog2(NUM_COL) + 1;
  localparam int WW = AW + 1;
  localparam logic [WW-1:0] WORD_END = WW'(BUFFER_SIZE);
  localparam logic [IW-1:0] COL_LAST = IW'(NUM_COL - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_e;

  state_e                state_q, state_d;
  logic [WW-1:0]         word_q, word_d;    // index of the next word to emit
  logic [7:0]            grp_q, grp_d;      // position within the current column run
  logic [IW-1:0]         col_q, col_d;      // zero-based column of the next word
  logic [7:0]            ks_q, ks_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]         id_q, id_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  emit;
  logic [7:0]            ks_use;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    grp_d   = grp_q;
    col_d   = col_q;
    ks_d    = ks_q;
    data_d  = data_q;
    addr_d  = addr_q;
    id_d    = '0;
    valid_d = 1'b0;
    emit    = 1'b0;
    ks_use  = ks_q;

    case (state_q)
      S_IDLE: begin
        if (bus.load) begin
          // First word's group advance must already use the freshly latched size.
          ks_use  = (bus.kernel_size == 8'd0) ? 8'd1 : bus.kernel_size;
          ks_d    = ks_use;
          emit    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Burst completion wins over load so DONE follows the last word directly.
        if (word_q == WORD_END) state_d = S_DONE;
        else if (bus.load)      emit    = 1'b1;
        else                    state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (bus.load) begin
          emit    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        if (!bus.load) begin
          state_d = S_IDLE;
          word_d  = '0;
          grp_d   = '0;
          col_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (emit) begin
      addr_d  = word_q[AW-1:0];
      data_d  = DATA_WIDTH'(word_q) + DATA_WIDTH'(1);
      id_d    = col_q + IW'(1);
      valid_d = 1'b1;
      word_d  = word_q + WW'(1);
      if (grp_q == ks_use - 8'd1) begin
        grp_d = '0;
        col_d = (col_q == COL_LAST) ? '0 : col_q + IW'(1);
      end else begin
        grp_d = grp_q + 8'd1;
      end
    end

    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      word_q  <= '0;
      grp_q   <= '0;
      col_q   <= '0;
      ks_q    <= 8'd1;
      data_q  <= '0;
      id_q    <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      grp_q   <= grp_d;
      col_q   <= col_d;
      ks_q    <= ks_d;
      data_q  <= data_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.id_out    = id_q;
  assign bus.addr_out  = addr_q;
  assign bus.valid_out = valid_q;
  assign bus.done      = done_q;
endmodule

// File: tb/tb_buf_writer_gen.sv
module tb_buf_writer_gen;
  localparam int NUM_COL     = 10;
  localparam int BUFFER_SIZE = 512;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       load = 1'b0;
  logic [7:0] kernel_size = 8'd5;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  buf_writer_gen_if #(.DATA_WIDTH(16), .NUM_COL(NUM_COL), .BUFFER_SIZE(BUFFER_SIZE)) if16 ();
  buf_writer_gen_if #(.DATA_WIDTH(32), .NUM_COL(NUM_COL), .BUFFER_SIZE(BUFFER_SIZE)) if32 ();

  assign if16.load        = load;
  assign if16.kernel_size = kernel_size;
  assign if32.load        = load;
  assign if32.kernel_size = kernel_size;

  buf_writer_gen #(.DATA_WIDTH(16), .NUM_COL(NUM_COL), .BUFFER_SIZE(BUFFER_SIZE)) dut16 (
    .clk(clk), .rstn(rstn), .bus(if16.master));
  buf_writer_gen #(.DATA_WIDTH(32), .NUM_COL(NUM_COL), .BUFFER_SIZE(BUFFER_SIZE)) dut32 (
    .clk(clk), .rstn(rstn), .bus(if32.master));

  // Behavioural model: words emitted so far, latched size, and the write
  // that the current outputs must show.
  int unsigned m_n = 0, m_ks = 1, m_addr = 0, m_data = 0, m_id = 0;
  bit          m_started = 0, m_done = 0, m_valid = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_n <= 0; m_ks <= 1; m_addr <= 0; m_data <= 0; m_id <= 0;
      m_started <= 0; m_done <= 0; m_valid <= 0;
    end else if (m_done) begin
      m_valid <= 0; m_id <= 0;
      if (!load) begin
        m_done <= 0; m_n <= 0; m_started <= 0;
      end
    end else if (m_n == BUFFER_SIZE) begin
      m_done <= 1; m_valid <= 0; m_id <= 0;
    end else if (load) begin
      int unsigned ks;
      ks = m_started ? m_ks : ((kernel_size == 0) ? 1 : int'(kernel_size));
      m_ks      <= ks;
      m_started <= 1;
      m_addr    <= m_n;
      m_data    <= m_n + 1;
      m_id      <= ((m_n / ks) % NUM_COL) + 1;
      m_valid   <= 1;
      m_n       <= m_n + 1;
    end else begin
      m_valid <= 0; m_id <= 0;
    end
  end

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("addr16",  if16.addr_out,  m_addr);
    chk("data16",  if16.data_out,  16'(m_data));
    chk("id16",    if16.id_out,    m_id);
    chk("valid16", if16.valid_out, m_valid);
    chk("done16",  if16.done,      m_done);
    chk("addr32",  if32.addr_out,  m_addr);
    chk("data32",  if32.data_out,  m_data);
    chk("id32",    if32.id_out,    m_id);
    chk("valid32", if32.valid_out, m_valid);
    chk("done32",  if32.done,      m_done);
  end

  // Drive inputs at a negedge, return at the next negedge (one active edge later).
  task automatic step(input logic l, input logic [7:0] k);
    load = l;
    kernel_size = k;
    @(negedge clk);
  endtask

  task automatic lit(input string tag, input int unsigned a, input int unsigned d,
                     input int unsigned id, input bit v, input bit dn);
    chk({tag, "_addr"},  if16.addr_out,  a);
    chk({tag, "_data"},  if32.data_out,  d);
    chk({tag, "_id"},    if16.id_out,    id);
    chk({tag, "_valid"}, if16.valid_out, v);
    chk({tag, "_done"},  if16.done,      dn);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    // Reset held with load high: outputs stay cleared.
    load = 1'b1; kernel_size = 8'd5;
    repeat (3) @(negedge clk);
    lit("rst", 0, 0, 0, 0, 0);
    rstn = 1'b1;
    step(1, 5);
    lit("w0", 0, 1, 1, 1, 0);

    // Basic burst, ks=5.
    repeat (49) step(1, 5);
    lit("w49", 49, 50, 10, 1, 0);
    step(0, 5);
    lit("pause49", 49, 50, 0, 0, 0);

    // Pause/resume; kernel_size change during pause is ignored.
    do_reset();
    repeat (7) step(1, 5);
    repeat (3) step(0, 3);
    step(1, 3);
    lit("resume7", 7, 8, 2, 1, 0);
    repeat (504) step(1, 3);
    lit("w511", 511, 512, 3, 1, 0);
    step(1, 3);
    lit("done", 511, 512, 0, 0, 1);
    step(1, 3);
    lit("done_hold", 511, 512, 0, 0, 1);
    step(0, 5);
    lit("idle", 511, 512, 0, 0, 0);
    step(1, 5);
    lit("restart", 0, 1, 1, 1, 0);

    // kernel_size 0 behaves as 1.
    do_reset();
    repeat (10) step(1, 0);
    lit("ks0_w9", 9, 10, 10, 1, 0);
    step(1, 0);
    lit("ks0_w10", 10, 11, 1, 1, 0);
    repeat (10) step(1, 0);
    lit("ks0_w20", 20, 21, 1, 1, 0);

    // Asynchronous reset between clock edges.
    #2 rstn = 1'b0;
    #1 lit("async", 0, 0, 0, 0, 0);
    chk("async_data16", if16.data_out, 0);
    @(negedge clk);
    rstn = 1'b1;
    step(1, 4);
    lit("post_w0", 0, 1, 1, 1, 0);
    repeat (4) step(1, 4);
    lit("post_w4", 4, 5, 2, 1, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      logic       l;
      logic [7:0] k;
      l = load;
      k = kernel_size;
      if ($urandom_range(0, 99) < 15) l = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 5)  k = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 999) < 3) begin
        load = l; kernel_size = k;
        do_reset();
      end else begin
        step(l, k);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
